irq_pend_ctrl_8: RTL
====================

Name: irq_pend_ctrl_8

Overview:
Interrupt pending/acknowledge controller that sits directly upstream of the team's 8x3 priority encoder (encoder_8x3_priority).
- Captures 8 request lines into a pending register and applies an enable mask.
- Drives the masked pending vector into the encoder.
- Takes back the 3-bit winning index and presents it to a consumer over a valid/ready handshake.
- Clears the accepted pending bit on handshake.

Parameters:
EDGE_SEL, 8'hFF, per-line mode: 1 = rising-edge capture, 0 = level capture
MASK_RST, 8'h00, reset value of the enable mask (1 = line enabled)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  8  request lines, synchronous to clk
mask_we  in  1  mask write strobe
mask_wdata  in  8  new mask value
mask  out  8  current mask
pend_vec  out  8  pend & mask; drives encoder input a
enc_id  in  3  encoder output y
irq_valid  out  1  irq_id is valid
irq_id  out  3  presented request index
irq_ready  in  1  consumer accepts irq_id
overrun  out  8  sticky per-line lost-edge flags
overrun_clr  in  8  write-1-to-clear for overrun

Behaviour:
- Reset (async, rst_n=0):
  - pend, req_q, overrun, irq_valid and irq_id all clear to 0.
  - mask resets to MASK_RST. FSM enters IDLE.
  - Outputs change immediately on reset assertion, not at the next clock edge.
  - A request mid-handshake is dropped.
- Capture:
  - req_q holds req from the previous cycle.
  - Edge lines: set_i = req[i] & ~req_q[i]. Level lines: set_i = req[i].
  - pend[i] is set at the end of the cycle in which set_i=1.
  - A line already high at reset release counts as a rising edge, because req_q resets to 0.
- Masking:
  - A masked line still latches pend.
  - Unmasking the line later exposes it on pend_vec in the cycle after the mask write.
  - mask_we updates mask at the clock edge.
- Overrun:
  - An edge line with set_i=1 while pend[i]=1 and no clear of bit i that cycle sets overrun[i].
  - overrun_clr[i]=1 clears overrun[i]. If set and clear occur in the same cycle, set wins.
- FSM states IDLE, PRESENT, GAP:
  - IDLE: if |pend_vec, latch irq_id <= enc_id, set irq_valid <= 1, go to PRESENT. Else stay.
  - PRESENT: irq_valid=1, irq_id frozen. Higher-priority arrivals and mask changes do not alter or withdraw irq_id.
  - PRESENT, irq_ready=1: clear pend[irq_id], irq_valid <= 0, go to GAP.
  - PRESENT, irq_ready=0: hold.
  - GAP: one dead cycle so the encoder sees the updated pend_vec. Always go to IDLE.
  - irq_ready is ignored outside PRESENT.
- Latency: edge in cycle t -> pend set end of t -> irq_valid high in cycle t+2.
- Throughput: back-to-back accepts give one grant per 3 cycles (PRESENT 1 cycle, GAP, IDLE).
- Simultaneous set and clear of the same pend bit in one cycle: set wins, so a new event is not lost. For level lines this means a line held high re-presents.
- enc_id is used only when |pend_vec=1. The encoder outputs 0 for an all-zero vector, so that value is never latched.
- Priority: highest index wins, as decided by the encoder; this block does not re-prioritise.

Decomposition:
- Shared package irq_pkg holds:
  - typedef irq_id_t (logic [2:0]) and irq_vec_t (logic [7:0])
  - enum irq_state_e {IDLE, PRESENT, GAP}
  - constant N_IRQ = 8
- No sub-module inside this block; the encoder stays a separate instance wired at the parent.
- The bench top instantiates both blocks, connecting pend_vec -> a and y -> enc_id.

Test Plan:
- Single edge: mask=FF, pulse req[5] one cycle at t -> irq_valid=1, irq_id=5 at t+2; ready=1 -> pend=00, irq_valid=0 next cycle.
- Priority and freeze:
  - req[2] edge, then req[6] edge while PRESENT with irq_id=2 -> irq_id stays 2 until accept.
  - After GAP, next grant is 6.
- Mask: mask=00, edge on req[3] -> no irq_valid, pend_vec=00. Write mask=08 -> irq_valid with id 3 two cycles later.
- Overrun and set-wins:
  - Second edge on req[1] while pend[1]=1 -> overrun=02; overrun_clr=02 -> overrun=00.
  - Edge on req[1] in the same cycle it is accepted -> pend[1] stays 1, re-presented.
- Level line: EDGE_SEL=FE, hold req[0]=1, ready held 1 -> id 0 granted every 3 cycles; overrun[0] never sets.
- Reset mid-handshake: in PRESENT with id 4, drop rst_n asynchronously -> irq_valid, irq_id, pend and overrun go 0 before the next clk edge; mask=MASK_RST.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types for the interrupt pending/acknowledge controller and its encoder.
package irq_pkg;

  localparam int N_IRQ = 8;

  typedef logic [2:0]       irq_id_t;
  typedef logic [N_IRQ-1:0] irq_vec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } irq_state_e;

  function automatic irq_vec_t id_to_vec(input irq_id_t id);
    irq_vec_t v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/encoder_8x3_priority.sv
// 8-to-3 priority encoder: highest set index wins, all-zero input gives 0.
module encoder_8x3_priority
  import irq_pkg::*;
(
  input  irq_vec_t a,
  output irq_id_t  y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (a[i]) y = irq_id_t'(i);
    end
  end

endmodule

// File: rtl/irq_pend_ctrl_8.sv
// Interrupt pending/acknowledge controller: captures requests, masks them for an
// external priority encoder, and hands the winning index out over valid/ready.
//
//   state   | meaning
//   IDLE    | waiting for any enabled pending line; latches encoder result
//   PRESENT | irq_id frozen and valid, waiting for irq_ready
//   GAP     | dead cycle so the encoder sees the cleared pend bit
module irq_pend_ctrl_8
  import irq_pkg::*;
#(
  parameter irq_vec_t EDGE_SEL = 8'hFF,
  parameter irq_vec_t MASK_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  output logic [7:0] mask,
  output logic [7:0] pend_vec,
  input  logic [2:0] enc_id,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  input  logic       irq_ready,
  output logic [7:0] overrun,
  input  logic [7:0] overrun_clr
);

  irq_state_e state;
  irq_vec_t   req_q;
  irq_vec_t   pend;
  irq_vec_t   edge_set;
  irq_vec_t   set_vec;
  irq_vec_t   clr_vec;
  irq_vec_t   ovr_set;

  always_comb begin
    edge_set = req & ~req_q & EDGE_SEL;
    set_vec  = edge_set | (req & ~EDGE_SEL);
    clr_vec  = '0;
    if (state == PRESENT && irq_ready) clr_vec = id_to_vec(irq_id);
    // A fresh edge on a line that is still pending and not being cleared is lost.
    ovr_set  = edge_set & pend & ~clr_vec;
  end

  assign pend_vec = pend & mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      pend    <= '0;
      overrun <= '0;
    end else begin
      req_q   <= req;
      pend    <= (pend & ~clr_vec) | set_vec;
      overrun <= (overrun & ~overrun_clr) | ovr_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= MASK_RST;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pend_vec) begin
            irq_id    <= enc_id;
            irq_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ready) begin
            irq_valid <= 1'b0;
            state     <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          irq_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
